// File: rtl/sprite_mover.sv
// Bouncing-box sprite: per-frame motion controller with edge clamping and a
// one-pixel-latency renderer that paints the box over a flat background.
module sprite_mover #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned BOX_W     = 32,
  parameter int unsigned BOX_H     = 32,
  parameter logic [11:0] FG_RGB    = 12'hF00,
  parameter logic [11:0] BG_RGB    = 12'hFFF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PIX_EN,
  input  logic       FRAME_START,
  input  logic       DE,
  input  logic [9:0] X,
  input  logic [9:0] Y,
  input  logic [2:0] SPEED,
  input  logic       PAUSE,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       DE_OUT,
  output logic [9:0] BOX_X,
  output logic [9:0] BOX_Y,
  output logic       HIT
);

  localparam int unsigned CW      = 11;
  localparam logic [CW-1:0] X_MAX = CW'(H_DISPLAY - BOX_W);
  localparam logic [CW-1:0] Y_MAX = CW'(V_DISPLAY - BOX_H);
  localparam logic [CW-1:0] BW    = CW'(BOX_W);
  localparam logic [CW-1:0] BH    = CW'(BOX_H);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t        r_state;
  logic [9:0]    r_box_x;
  logic [9:0]    r_box_y;
  logic          r_dir_x;   // 0 = moving positive, 1 = moving negative
  logic          r_dir_y;
  logic          r_hit;
  logic [11:0]   r_rgb;
  logic          r_de_out;

  logic          w_strobe;
  logic          w_move;
  logic [CW-1:0] w_step;
  logic [CW-1:0] w_x_res;
  logic [CW-1:0] w_y_res;
  logic          w_inside;

  // One axis step: returns {bounce, new_position}; 11-bit math never wraps.
  function automatic logic [CW-1:0] axis_step(input logic [9:0]    pos,
                                               input logic          dir,
                                               input logic [CW-1:0] step,
                                               input logic [CW-1:0] lim);
    logic [CW-1:0] sum;
    logic [CW-1:0] res;
    sum = {1'b0, pos} + step;
    res = {1'b0, pos};
    if (!dir) begin
      if (sum >= lim) res = {1'b1, lim[9:0]};
      else            res = {1'b0, sum[9:0]};
    end else if ({1'b0, pos} <= step) begin
      res = {1'b1, 10'd0};
    end else begin
      res = {1'b0, pos - step[9:0]};
    end
    return res;
  endfunction

  always_comb begin
    w_strobe = FRAME_START & PIX_EN;
    w_step   = {8'd0, SPEED};
    // SPEED=0 is a true no-op so a parked box never bounces in place
    w_move   = w_strobe & ~PAUSE & (SPEED != 3'd0) &
               ((r_state == S_RUN) | (r_state == S_PAUSED));
    w_x_res  = axis_step(r_box_x, r_dir_x, w_step, X_MAX);
    w_y_res  = axis_step(r_box_y, r_dir_y, w_step, Y_MAX);
    w_inside = ({1'b0, X} >= {1'b0, r_box_x}) &&
               ({1'b0, X} <  ({1'b0, r_box_x} + BW)) &&
               ({1'b0, Y} >= {1'b0, r_box_y}) &&
               ({1'b0, Y} <  ({1'b0, r_box_y} + BH));
  end

  // Motion FSM: state, position and direction only change on frame strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_box_x <= 10'd0;
      r_box_y <= 10'd0;
      r_dir_x <= 1'b0;
      r_dir_y <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      if (w_strobe) begin
        case (r_state)
          S_IDLE:   r_state <= S_RUN;
          S_RUN:    if (PAUSE)  r_state <= S_PAUSED;
          S_PAUSED: if (!PAUSE) r_state <= S_RUN;
          default:  r_state <= S_IDLE;
        endcase
      end
      if (w_move) begin
        r_box_x <= w_x_res[9:0];
        r_box_y <= w_y_res[9:0];
        r_dir_x <= r_dir_x ^ w_x_res[10];
        r_dir_y <= r_dir_y ^ w_y_res[10];
        r_hit   <= w_x_res[10] | w_y_res[10];
      end
    end
  end

  // Renderer: one register stage, advanced on the pixel enable only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rgb    <= 12'h000;
      r_de_out <= 1'b0;
    end else if (PIX_EN) begin
      r_de_out <= DE;
      if (!DE)          r_rgb <= 12'h000;
      else if (w_inside) r_rgb <= FG_RGB;
      else              r_rgb <= BG_RGB;
    end
  end

  assign VGA_R  = r_rgb[11:8];
  assign VGA_G  = r_rgb[7:4];
  assign VGA_B  = r_rgb[3:0];
  assign DE_OUT = r_de_out;
  assign BOX_X  = r_box_x;
  assign BOX_Y  = r_box_y;
  assign HIT    = r_hit;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: motion, pause, bounce, corner, render and
// reset-priority scenarios with hand-computed expected values.
module tb_sprite_mover;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PIX_EN;
  logic       FRAME_START;
  logic       FRAME_START2;
  logic       DE;
  logic [9:0] X;
  logic [9:0] Y;
  logic [2:0] SPEED;
  logic       PAUSE;

  logic [3:0] VGA_R, VGA_G, VGA_B;
  logic       DE_OUT;
  logic [9:0] BOX_X, BOX_Y;
  logic       HIT;

  logic [3:0] SQ_R, SQ_G, SQ_B;
  logic       SQ_DE_OUT;
  logic [9:0] SQ_X, SQ_Y;
  logic       SQ_HIT;

  int   n_checks  = 0;
  int   n_errors  = 0;
  int   hit_count = 0;
  logic hit1, hit2;

  wire [11:0] rgb    = {VGA_R, VGA_G, VGA_B};
  wire [11:0] sq_rgb = {SQ_R, SQ_G, SQ_B};

  always #5 CLK = ~CLK;

  sprite_mover u_dut (
    .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN), .FRAME_START(FRAME_START),
    .DE(DE), .X(X), .Y(Y), .SPEED(SPEED), .PAUSE(PAUSE),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .DE_OUT(DE_OUT),
    .BOX_X(BOX_X), .BOX_Y(BOX_Y), .HIT(HIT)
  );

  // Square playfield so both axes reach their limit on the same strobe.
  sprite_mover #(.H_DISPLAY(640), .V_DISPLAY(640)) u_sq (
    .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN), .FRAME_START(FRAME_START2),
    .DE(DE), .X(X), .Y(Y), .SPEED(SPEED), .PAUSE(PAUSE),
    .VGA_R(SQ_R), .VGA_G(SQ_G), .VGA_B(SQ_B), .DE_OUT(SQ_DE_OUT),
    .BOX_X(SQ_X), .BOX_Y(SQ_Y), .HIT(SQ_HIT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic check_pos(input string tag, input bit sq, input int ex, input int ey);
    if (sq) begin
      check({tag, ".x"}, 32'(SQ_X), 32'(ex));
      check({tag, ".y"}, 32'(SQ_Y), 32'(ey));
    end else begin
      check({tag, ".x"}, 32'(BOX_X), 32'(ex));
      check({tag, ".y"}, 32'(BOX_Y), 32'(ey));
    end
  endtask

  // One frame strobe; hit1 is HIT right after the strobe edge, hit2 one cycle later.
  task automatic strobe(input logic [2:0] spd, input bit sq);
    SPEED = spd;
    PIX_EN = 1'b1;
    if (sq) FRAME_START2 = 1'b1;
    else    FRAME_START  = 1'b1;
    @(posedge CLK); #1;
    FRAME_START  = 1'b0;
    FRAME_START2 = 1'b0;
    PIX_EN       = 1'b0;
    hit1 = sq ? SQ_HIT : HIT;
    @(posedge CLK); #1;
    hit2 = sq ? SQ_HIT : HIT;
    hit_count += int'(hit1) + int'(hit2);
  endtask

  task automatic run(input int n, input logic [2:0] spd, input bit sq);
    for (int i = 0; i < n; i++) strobe(spd, sq);
  endtask

  // One pixel on PIX_EN, then an idle cycle with scrambled inputs that must not leak.
  task automatic pix(input string tag, input logic [9:0] px, input logic [9:0] py,
                     input logic de, input logic [11:0] exp_rgb);
    X = px; Y = py; DE = de; PIX_EN = 1'b1;
    @(posedge CLK); #1;
    check({tag, ".rgb"}, 32'(rgb), 32'(exp_rgb));
    check({tag, ".de"},  32'(DE_OUT), 32'(de));
    PIX_EN = 1'b0; X = px + 10'd200; Y = py + 10'd100; DE = ~de;
    @(posedge CLK); #1;
    check({tag, ".hold_rgb"}, 32'(rgb), 32'(exp_rgb));
    check({tag, ".hold_de"},  32'(DE_OUT), 32'(de));
  endtask

  initial begin
    RST = 1'b1; PIX_EN = 1'b0; FRAME_START = 1'b0; FRAME_START2 = 1'b0;
    DE = 1'b0; X = '0; Y = '0; SPEED = 3'd0; PAUSE = 1'b0;
    hit1 = 1'b0; hit2 = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check_pos("reset", 1'b0, 0, 0);
    check("reset.hit", 32'(HIT), 32'd0);
    check("reset.rgb", 32'(rgb), 32'd0);
    check("reset.de",  32'(DE_OUT), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // First strobe only leaves IDLE, second moves by SPEED
    strobe(3'd3, 1'b0);
    check_pos("idle_exit", 1'b0, 0, 0);
    strobe(3'd3, 1'b0);
    check_pos("first_move", 1'b0, 3, 3);
    check("first_move.hit", 32'(hit1), 32'd0);

    // Pause holds position for three strobes; release moves on the same strobe
    PAUSE = 1'b1;
    run(3, 3'd5, 1'b0);
    check_pos("paused", 1'b0, 3, 3);
    PAUSE = 1'b0;
    strobe(3'd3, 1'b0);
    check_pos("unpause", 1'b0, 6, 6);
    strobe(3'd0, 1'b0);
    check_pos("speed0", 1'b0, 6, 6);

    // Walk to (100,100) for the render checks
    hit_count = 0;
    run(13, 3'd7, 1'b0);
    strobe(3'd3, 1'b0);
    check_pos("to_100", 1'b0, 100, 100);
    check("to_100.hits", 32'(hit_count), 32'd0);

    pix("px_x99",  10'd99,  10'd100, 1'b1, 12'hFFF);
    pix("px_x100", 10'd100, 10'd100, 1'b1, 12'hF00);
    pix("px_x131", 10'd131, 10'd100, 1'b1, 12'hF00);
    pix("px_x132", 10'd132, 10'd100, 1'b1, 12'hFFF);
    pix("px_y99",  10'd110, 10'd99,  1'b1, 12'hFFF);
    pix("px_y131", 10'd110, 10'd131, 1'b1, 12'hF00);
    pix("px_y132", 10'd110, 10'd132, 1'b1, 12'hFFF);
    pix("px_de0",  10'd110, 10'd110, 1'b0, 12'h000);

    // Bottom bounce: Y lands exactly on 448 and flips
    run(48, 3'd7, 1'b0);
    strobe(3'd5, 1'b0);
    check_pos("near_bottom", 1'b0, 441, 441);
    check("near_bottom.hits", 32'(hit_count), 32'd0);
    strobe(3'd7, 1'b0);
    check_pos("y_bounce", 1'b0, 448, 448);
    check("y_bounce.hit1", 32'(hit1), 32'd1);
    check("y_bounce.hit2", 32'(hit2), 32'd0);
    strobe(3'd0, 1'b0);
    check_pos("edge_speed0", 1'b0, 448, 448);
    check("edge_speed0.hit", 32'(hit1), 32'd0);

    // Right-edge bounce from 606 with SPEED=4
    hit_count = 0;
    run(22, 3'd7, 1'b0);
    strobe(3'd4, 1'b0);
    check_pos("at_606", 1'b0, 606, 290);
    strobe(3'd4, 1'b0);
    check_pos("x_bounce", 1'b0, 608, 286);
    check("x_bounce.hit1", 32'(hit1), 32'd1);
    check("x_bounce.hit2", 32'(hit2), 32'd0);
    strobe(3'd1, 1'b0);
    check_pos("x_neg", 1'b0, 607, 285);
    check("x_bounce.hits", 32'(hit_count), 32'd1);

    // Reset lands on a strobe that would bounce Y off the top
    run(40, 3'd7, 1'b0);
    check_pos("near_top", 1'b0, 327, 5);
    pix("pre_rst", 10'd0, 10'd0, 1'b1, 12'hFFF);
    X = 10'd330; Y = 10'd10; DE = 1'b1;
    SPEED = 3'd7; FRAME_START = 1'b1; PIX_EN = 1'b1; RST = 1'b1;
    @(posedge CLK); #1;
    check_pos("rst_bounce", 1'b0, 0, 0);
    check("rst_bounce.hit", 32'(HIT), 32'd0);
    check("rst_bounce.rgb", 32'(rgb), 32'd0);
    check("rst_bounce.de",  32'(DE_OUT), 32'd0);
    check("rst_bounce.sq",  32'({sq_rgb, SQ_DE_OUT}), 32'd0);
    RST = 1'b0; FRAME_START = 1'b0; PIX_EN = 1'b0;
    @(posedge CLK); #1;
    check("rst_after.hit", 32'(HIT), 32'd0);
    strobe(3'd3, 1'b0);
    check_pos("rst_idle", 1'b0, 0, 0);
    strobe(3'd3, 1'b0);
    check_pos("rst_run", 1'b0, 3, 3);

    // Corner on the square instance: both axes clamp together, one HIT
    strobe(3'd7, 1'b1);
    check_pos("sq_idle", 1'b1, 0, 0);
    hit_count = 0;
    run(86, 3'd7, 1'b1);
    check_pos("sq_near", 1'b1, 602, 602);
    check("sq_near.hits", 32'(hit_count), 32'd0);
    strobe(3'd7, 1'b1);
    check_pos("corner", 1'b1, 608, 608);
    check("corner.hit1", 32'(hit1), 32'd1);
    check("corner.hit2", 32'(hit2), 32'd0);
    strobe(3'd1, 1'b1);
    check_pos("corner_neg", 1'b1, 607, 607);
    check("corner.hits", 32'(hit_count), 32'd1);
    check_pos("main_still", 1'b0, 3, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 SHALL have parameters: H_DISPLAY, default 640, visible width in pixels.
REQ-002 SHALL have parameters: V_DISPLAY, default 480, visible height in lines.
REQ-003 SHALL have parameters: BOX_W and BOX_H, default 32 each, box size in pixels.
REQ-004 SHALL have parameters: FG_RGB, default 12'hF00, box colour; BG_RGB, default 12'hFFF, background colour.
REQ-005 SHALL have port CLK, input, 1 bit, system clock; the block uses one clock only.
REQ-006 SHALL have port RST, input, 1 bit, reset; synchronous, active-high.
REQ-007 SHALL have port PIX_EN, input, 1 bit, pixel-rate enable (25 MHz tick).
REQ-008 SHALL have port FRAME_START, input, 1 bit, one-pixel pulse issued in vertical blanking, qualified by PIX_EN.
REQ-009 SHALL have port DE, input, 1 bit, display-active for the current X/Y.
REQ-010 SHALL have ports X and Y, input, 10 bits each, display-relative pixel coordinates.
REQ-011 SHALL have port SPEED, input, 3 bits, motion step in pixels per frame per axis.
REQ-012 SHALL have port PAUSE, input, 1 bit, freezes motion while high.
REQ-013 SHALL have ports VGA_R, VGA_G and VGA_B, output, 4 bits each, pixel colour.
REQ-014 SHALL have port DE_OUT, output, 1 bit, DE delayed to align with the colour outputs.
REQ-015 SHALL have ports BOX_X and BOX_Y, output, 10 bits each, top-left corner of the box.
REQ-016 SHALL have port HIT, output, 1 bit, one-CLK pulse on any bounce.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and PAUSED; all transitions are evaluated only when FRAME_START & PIX_EN is high.
REQ-018 IDLE SHALL go to RUN on the first frame strobe; the box does not move on that strobe.
REQ-019 RUN with PAUSE=1 SHALL go to PAUSED with no move; PAUSED with PAUSE=0 SHALL go to RUN and move on the same strobe.
REQ-020 In RUN, each strobe SHALL sample SPEED once and update both axes in the same CLK cycle.
REQ-021 X-axis moving positive: nx = BOX_X + SPEED; if nx >= H_DISPLAY-BOX_W, BOX_X SHALL clamp to H_DISPLAY-BOX_W and the direction SHALL flip to negative.
REQ-022 X-axis moving negative: if BOX_X <= SPEED, BOX_X SHALL clamp to 0 and the direction SHALL flip to positive; otherwise BOX_X SHALL become BOX_X - SPEED.
REQ-023 The Y axis SHALL behave identically using V_DISPLAY and BOX_H; arithmetic SHALL use 11-bit intermediates so it never wraps.
REQ-024 On a simultaneous X and Y bounce (corner), both directions SHALL flip and HIT SHALL pulse exactly once.
REQ-025 SPEED=0 SHALL cause no move and no HIT, even at an edge.
REQ-026 HIT SHALL be high for exactly one CLK cycle, the cycle after the strobe that caused the clamp.
REQ-027 Render SHALL update registers only when PIX_EN=1, with 1 PIX_EN-cycle latency from X/Y/DE to the colour outputs and DE_OUT.
REQ-028 Render colour: DE=0 gives 0/0/0; a pixel inside the box gives FG_RGB; any other pixel gives BG_RGB.
REQ-029 "Inside the box" SHALL mean BOX_X <= X < BOX_X+BOX_W and BOX_Y <= Y < BOX_Y+BOX_H.
REQ-030 Render outputs SHALL hold their value in cycles where PIX_EN=0.
REQ-031 The box position SHALL change only on strobes, so rendering within a frame is tear-free.

Reset
REQ-032 When RST is high at a CLK edge, the block SHALL enter IDLE.
REQ-033 On that edge BOX_X and BOX_Y SHALL become 0, both directions SHALL become positive, and HIT SHALL become 0.
REQ-034 On that edge VGA_R, VGA_G, VGA_B and DE_OUT SHALL become 0.
REQ-035 RST SHALL take priority over FRAME_START and PIX_EN, including mid-frame and mid-bounce.
REQ-036 After RST is released, the first strobe SHALL only leave IDLE (REQ-018).

Verification
REQ-037 Reset, then two strobes with SPEED=3 -> BOX_X=3 and BOX_Y=3, no HIT.
REQ-038 Force BOX_X=606 moving positive, SPEED=4, then one strobe -> BOX_X=608, direction negative, HIT one cycle.
REQ-039 Box at (608,448) moving +,+, SPEED=7, then one strobe -> (608,448) clamped, both directions negative, exactly one HIT pulse.
REQ-040 In RUN, hold PAUSE=1 for 3 strobes -> position unchanged; release PAUSE -> moves on that strobe.
REQ-041 Box at (100,50), PIX_EN every 2nd CLK, X=99/100/131/132 with Y=50 and DE=1 -> BG/FG/FG/BG, each one PIX_EN later; DE=0 gives black.
REQ-042 Assert RST in the cycle of a bouncing strobe -> no HIT, outputs 0, state IDLE.
